// File: rtl/regfile_wb_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_sched_if
//  Description : Bundles the issue, ALU/MEM write-back and register-file
//                write-port signals of the write-back scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_sched_if #(
   parameter int DW   = 8,
   parameter int AW   = 3,
   parameter int NREG = 8
);
   // Issue stage
   logic            iss_valid;
   logic [AW-1:0]   iss_rd;
   logic [AW-1:0]   iss_s1;
   logic [AW-1:0]   iss_s2;
   logic            iss_stall;
   // ALU write-back source
   logic            alu_valid;
   logic [AW-1:0]   alu_rd;
   logic [DW-1:0]   alu_data;
   logic            alu_ready;
   // MEM write-back source
   logic            mem_valid;
   logic [AW-1:0]   mem_rd;
   logic [DW-1:0]   mem_data;
   logic            mem_ready;
   // Register-file write port and scoreboard
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [DW-1:0]   rf_wdata;
   logic [NREG-1:0] busy;

   modport master (
      output iss_valid, iss_rd, iss_s1, iss_s2,
      output alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data,
      input  iss_stall, alu_ready, mem_ready,
      input  rf_we, rf_waddr, rf_wdata, busy
   );

   modport slave (
      input  iss_valid, iss_rd, iss_s1, iss_s2,
      input  alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data,
      output iss_stall, alu_ready, mem_ready,
      output rf_we, rf_waddr, rf_wdata, busy
   );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_sched
//  Description : Round-robin arbiter of ALU/MEM write-backs onto the single
//                register-file write port, plus an in-flight destination
//                scoreboard that stalls issue on RAW/WAW hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_sched #(
   parameter int DW   = 8,
   parameter int AW   = 3,
   parameter int NREG = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   regfile_wb_sched_if.slave  bus
);

   // Round-robin pointer: which source wins the next contended cycle
   localparam logic [0:0] RR_ALU = 1'b0;
   localparam logic [0:0] RR_MEM = 1'b1;

   logic [0:0]      rr_q,       rr_d;
   logic            rf_we_q,    rf_we_d;
   logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
   logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
   logic [NREG-1:0] busy_q,     busy_d;

   logic            alu_gnt;
   logic            mem_gnt;
   logic            iss_stall;
   logic            iss_accept;

   // State register: pointer, write port and scoreboard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q       <= RR_ALU;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         rr_q       <= rr_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   // Grant selection and next pointer; the pointer only moves on contention
   always_comb begin
      alu_gnt = bus.alu_valid & (~bus.mem_valid | (rr_q == RR_ALU));
      mem_gnt = bus.mem_valid & (~bus.alu_valid | (rr_q == RR_MEM));
      rr_d    = rr_q;
      if (bus.alu_valid & bus.mem_valid) begin
         rr_d = alu_gnt ? RR_MEM : RR_ALU;
      end
   end

   // Next write-port contents; address/data hold when nothing is granted
   always_comb begin
      rf_we_d    = alu_gnt | mem_gnt;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (alu_gnt) begin
         rf_waddr_d = bus.alu_rd;
         rf_wdata_d = bus.alu_data;
      end else if (mem_gnt) begin
         rf_waddr_d = bus.mem_rd;
         rf_wdata_d = bus.mem_data;
      end
   end

   // Hazard check against the registered scoreboard (no commit bypass)
   always_comb begin
      iss_stall  = bus.iss_valid &
                   (busy_q[bus.iss_s1] | busy_q[bus.iss_s2] | busy_q[bus.iss_rd]);
      iss_accept = bus.iss_valid & ~iss_stall;
   end

   // Scoreboard update: commit clears, accepted issue sets; set applied last wins
   always_comb begin
      busy_d = busy_q;
      if (rf_we_q) begin
         busy_d[rf_waddr_q] = 1'b0;
      end
      if (iss_accept) begin
         busy_d[bus.iss_rd] = 1'b1;
      end
   end

   assign bus.alu_ready = alu_gnt;
   assign bus.mem_ready = mem_gnt;
   assign bus.iss_stall = iss_stall;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_waddr  = rf_waddr_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_sched
//  Description : Self-checking bench for regfile_wb_sched: directed vector
//                table, reset/contention sequences and a randomized run
//                against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_sched;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   regfile_wb_sched_if #(.DW(8), .AW(3), .NREG(8)) bus ();

   regfile_wb_sched #(.DW(8), .AW(3), .NREG(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic       iv;
      logic [2:0] ird, is1, is2;
      logic       av;
      logic [2:0] ard;
      logic [7:0] adat;
      logic       mv;
      logic [2:0] mrd;
      logic [7:0] mdat;
      logic       e_ardy, e_mrdy, e_stall, e_we;
      logic [2:0] e_waddr;
      logic [7:0] e_wdata;
      logic [7:0] e_busy;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   // Reference model state
   logic [7:0] m_busy;
   logic       m_we;
   logic [2:0] m_waddr;
   logic [7:0] m_wdata;
   logic       m_mem_turn;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(int iv, int ird, int is1, int is2,
                               int av, int ard, int adat,
                               int mv, int mrd, int mdat,
                               int ea, int em, int es, int ew,
                               int ewa, int ewd, int eb);
      vec_t v;
      v.iv = 1'(iv);  v.ird = 3'(ird);  v.is1 = 3'(is1);  v.is2 = 3'(is2);
      v.av = 1'(av);  v.ard = 3'(ard);  v.adat = 8'(adat);
      v.mv = 1'(mv);  v.mrd = 3'(mrd);  v.mdat = 8'(mdat);
      v.e_ardy = 1'(ea); v.e_mrdy = 1'(em); v.e_stall = 1'(es); v.e_we = 1'(ew);
      v.e_waddr = 3'(ewa); v.e_wdata = 8'(ewd); v.e_busy = 8'(eb);
      return v;
   endfunction

   task automatic set_in(int iv, int ird, int is1, int is2,
                         int av, int ard, int adat,
                         int mv, int mrd, int mdat);
      bus.iss_valid = 1'(iv);
      bus.iss_rd    = 3'(ird);
      bus.iss_s1    = 3'(is1);
      bus.iss_s2    = 3'(is2);
      bus.alu_valid = 1'(av);
      bus.alu_rd    = 3'(ard);
      bus.alu_data  = 8'(adat);
      bus.mem_valid = 1'(mv);
      bus.mem_rd    = 3'(mrd);
      bus.mem_data  = 8'(mdat);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_regs(string tag, int we, int wa, int wd, int bz);
      chk({tag, " rf_we"},    32'(bus.rf_we),    32'(we));
      chk({tag, " rf_waddr"}, 32'(bus.rf_waddr), 32'(wa));
      chk({tag, " rf_wdata"}, 32'(bus.rf_wdata), 32'(wd));
      chk({tag, " busy"},     32'(bus.busy),     32'(bz));
   endtask

   initial begin
      int ai, mi;
      int av, ard, adat, mv, mrd, mdat, iv, ird, is1, is2;
      bit a_hold, m_hold, alu_wins;
      logic e_ardy, e_mrdy, e_stall;
      logic [7:0] nb;

      // Directed table: sequential rows from a fresh reset
      vecs[0] = mk(0,0,0,0, 1,5,8'hA5, 0,0,0,     1,0,0, 1,5,8'hA5,8'h00);
      vecs[1] = mk(0,0,0,0, 1,1,8'h11, 1,2,8'h22, 1,0,0, 1,1,8'h11,8'h00);
      vecs[2] = mk(0,0,0,0, 0,0,0,     1,2,8'h22, 0,1,0, 1,2,8'h22,8'h00);
      vecs[3] = mk(1,3,0,0, 0,0,0,     0,0,0,     0,0,0, 0,2,8'h22,8'h08);
      vecs[4] = mk(1,6,3,0, 0,0,0,     1,3,8'h33, 0,1,1, 1,3,8'h33,8'h08);
      vecs[5] = mk(1,6,3,0, 0,0,0,     0,0,0,     0,0,1, 0,3,8'h33,8'h00);
      vecs[6] = mk(1,6,3,0, 0,0,0,     0,0,0,     0,0,0, 0,3,8'h33,8'h40);
      vecs[7] = mk(1,6,0,7, 1,4,8'h44, 1,5,8'h55, 0,1,1, 1,5,8'h55,8'h40);
      vecs[8] = mk(1,1,2,7, 1,4,8'h44, 0,0,0,     1,0,0, 1,4,8'h44,8'h42);
      vecs[9] = mk(0,0,0,0, 0,0,0,     0,0,0,     0,0,0, 0,4,8'h44,8'h42);

      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      #1;
      chk_regs("reset", 0, 0, 0, 0);
      chk("reset alu_ready", 32'(bus.alu_ready), 32'd0);
      chk("reset iss_stall", 32'(bus.iss_stall), 32'd0);

      // Table-driven pass
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         set_in(vecs[i].iv, vecs[i].ird, vecs[i].is1, vecs[i].is2,
                vecs[i].av, vecs[i].ard, vecs[i].adat,
                vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
         #1;
         chk($sformatf("v%0d alu_ready", i), 32'(bus.alu_ready), 32'(vecs[i].e_ardy));
         chk($sformatf("v%0d mem_ready", i), 32'(bus.mem_ready), 32'(vecs[i].e_mrdy));
         chk($sformatf("v%0d iss_stall", i), 32'(bus.iss_stall), 32'(vecs[i].e_stall));
         @(posedge clk);
         #1;
         chk_regs($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_waddr,
                  vecs[i].e_wdata, vecs[i].e_busy);
      end

      // Asynchronous reset mid-run with busy = 8'h24 and a commit in flight
      do_reset();
      @(negedge clk); set_in(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); set_in(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); set_in(0, 0, 0, 0, 1, 2, 8'h77, 0, 0, 0);
      @(posedge clk); #1;
      chk_regs("pre-reset", 1, 2, 8'h77, 8'h24);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_regs("async reset", 0, 0, 0, 0);
      chk("async reset mem_ready", 32'(bus.mem_ready), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk_regs("post-release", 0, 0, 0, 0);

      // Sustained contention: grants alternate starting with ALU
      ai = 0; mi = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         set_in(0, 0, 0, 0, 1, ai, 8'hA0 + ai, 1, 4 + mi, 8'hB0 + mi);
         #1;
         chk($sformatf("rr%0d alu_ready", k), 32'(bus.alu_ready), 32'((k % 2) == 0));
         chk($sformatf("rr%0d mem_ready", k), 32'(bus.mem_ready), 32'((k % 2) == 1));
         @(posedge clk); #1;
         if ((k % 2) == 0) begin
            chk_regs($sformatf("rr%0d", k), 1, ai, 8'hA0 + ai, 0);
            ai++;
         end else begin
            chk_regs($sformatf("rr%0d", k), 1, 4 + mi, 8'hB0 + mi, 0);
            mi++;
         end
      end
      chk("rr alu count", 32'(ai), 32'd3);
      chk("rr mem count", 32'(mi), 32'd3);

      // Randomized run against the reference model
      do_reset();
      m_busy = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_mem_turn = 1'b0;
      a_hold = 1'b0; m_hold = 1'b0;
      av = 0; ard = 0; adat = 0; mv = 0; mrd = 0; mdat = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!a_hold) begin
            av = ($urandom_range(0, 2) != 0) ? 1 : 0;
            ard = int'($urandom_range(0, 7));
            adat = int'($urandom_range(0, 255));
         end
         if (!m_hold) begin
            mv = ($urandom_range(0, 2) != 0) ? 1 : 0;
            mrd = int'($urandom_range(0, 7));
            mdat = int'($urandom_range(0, 255));
         end
         iv  = int'($urandom_range(0, 1));
         ird = int'($urandom_range(0, 7));
         is1 = int'($urandom_range(0, 7));
         is2 = int'($urandom_range(0, 7));
         set_in(iv, ird, is1, is2, av, ard, adat, mv, mrd, mdat);

         // Expected handshake: a lone requester wins; on contention the
         // source whose turn it is wins and the turn passes to the other
         e_stall = (iv != 0) && (m_busy[ird[2:0]] || m_busy[is1[2:0]] || m_busy[is2[2:0]]);
         if (av != 0 && mv != 0) alu_wins = !m_mem_turn;
         else                    alu_wins = (av != 0);
         e_ardy = (av != 0) && alu_wins;
         e_mrdy = (mv != 0) && !alu_wins;
         #1;
         chk($sformatf("rnd%0d alu_ready", c), 32'(bus.alu_ready), 32'(e_ardy));
         chk($sformatf("rnd%0d mem_ready", c), 32'(bus.mem_ready), 32'(e_mrdy));
         chk($sformatf("rnd%0d iss_stall", c), 32'(bus.iss_stall), 32'(e_stall));

         nb = m_busy;
         if (m_we) nb[m_waddr] = 1'b0;
         if (iv != 0 && !e_stall) nb[ird[2:0]] = 1'b1;
         m_busy = nb;
         if (av != 0 && mv != 0) m_mem_turn = alu_wins;
         m_we = e_ardy | e_mrdy;
         if (e_ardy) begin
            m_waddr = 3'(ard); m_wdata = 8'(adat);
         end else if (e_mrdy) begin
            m_waddr = 3'(mrd); m_wdata = 8'(mdat);
         end
         a_hold = (av != 0) && !e_ardy;
         m_hold = (mv != 0) && !e_mrdy;

         @(posedge clk); #1;
         chk_regs($sformatf("rnd%0d", c), m_we, m_waddr, m_wdata, m_busy);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
